// File: rtl/deser8way_pkg.sv
// Shared constants and state encoding for the bit-serial to 8-bit word collector.
package deser8way_pkg;

  localparam int unsigned WORD_W   = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned FULL_CNT = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/deser8way_or8way.sv
// 8-input OR reduction gate.
module deser8way_or8way (
  input  logic [7:0] a,
  output logic       y
);

  assign y = |a;

endmodule

// File: rtl/deser8way.sv
// Serial-to-parallel collector: assembles 8 accepted bits into a word held in a
// single-entry valid/ready output buffer, with an any-bit-set flag.
module deser8way
  import deser8way_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_nz
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [WORD_W-1:0]   out_d;
  logic                out_valid_d;

  logic                accept_c;
  logic                buf_free_c;
  logic [2:0]          pos_c;
  logic [WORD_W-1:0]   sh_new_c;

  // Readiness depends only on the counter state; held low while in reset.
  assign in_ready   = rst_n & (state_q == ACCUM);
  assign accept_c   = in_valid & in_ready;
  assign buf_free_c = ~out_valid | out_ready;
  assign pos_c      = LSB_FIRST ? cnt_q[2:0] : (3'd7 - cnt_q[2:0]);
  assign sh_new_c   = sh_q | (WORD_W'(in_bit) << pos_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      sh_q      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      out       <= out_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state: accumulate bits, park a completed word in FULL until the buffer frees.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    out_d       = out;
    out_valid_d = out_valid;

    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ACCUM: begin
        if (accept_c) begin
          if (cnt_q == CNT_W'(FULL_CNT - 1)) begin
            if (buf_free_c) begin
              out_d       = sh_new_c;
              out_valid_d = 1'b1;
              cnt_d       = '0;
              sh_d        = '0;
            end else begin
              sh_d    = sh_new_c;
              cnt_d   = CNT_W'(FULL_CNT);
              state_d = FULL;
            end
          end else begin
            sh_d  = sh_new_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (buf_free_c) begin
          out_d       = sh_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          sh_d        = '0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
        cnt_d   = '0;
        sh_d    = '0;
      end
    endcase
  end

  deser8way_or8way u_or8way (
    .a (out),
    .y (out_nz)
  );

endmodule

// File: tb/tb_deser8way.sv
// Directed self-checking bench for deser8way; runs an LSB-first and an MSB-first
// instance side by side on the same stimulus.
module tb_deser8way;

  logic       clk;
  logic       rst_n;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;
  logic       rdy_l, rdy_m;
  logic [7:0] out_l, out_m;
  logic       vld_l, vld_m;
  logic       nz_l, nz_m;

  int total = 0;
  int bad   = 0;

  deser8way #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy_l), .out(out_l), .out_valid(vld_l),
    .out_ready(out_ready), .out_nz(nz_l)
  );

  deser8way #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy_m), .out(out_m), .out_valid(vld_m),
    .out_ready(out_ready), .out_nz(nz_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_bit = w[i];
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    total++;
    if ({out_l, vld_l, nz_l, rdy_l} !== 11'h000) begin
      bad++; $display("FAIL reset_lsb: got out=%h v=%b nz=%b rdy=%b, want 00 0 0 0", out_l, vld_l, nz_l, rdy_l);
    end
    total++;
    if ({out_m, vld_m, nz_m, rdy_m} !== 11'h000) begin
      bad++; $display("FAIL reset_msb: got out=%h v=%b nz=%b rdy=%b, want 00 0 0 0", out_m, vld_m, nz_m, rdy_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({rdy_l, rdy_m, vld_l} !== 3'b110) begin
      bad++; $display("FAIL reset_release: got rdy=%b%b v=%b, want 11 0", rdy_l, rdy_m, vld_l);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [7:0] w;
    w = 8'h4D;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_bit = w[i];
      tick();
    end
    total++;
    if (vld_l !== 1'b0) begin
      bad++; $display("FAIL basic_latency: got out_valid=%b after 7 bits, want 0", vld_l);
    end
    in_bit = w[7];
    tick();
    total++;
    if (out_l !== 8'h4D) begin
      bad++; $display("FAIL basic_lsb_word: got %h, want 4d", out_l);
    end
    total++;
    if (out_m !== 8'hB2) begin
      bad++; $display("FAIL basic_msb_word: got %h, want b2", out_m);
    end
    total++;
    if ({vld_l, nz_l, rdy_l, vld_m, nz_m} !== 5'b11111) begin
      bad++; $display("FAIL basic_flags: got v=%b nz=%b rdy=%b vm=%b nzm=%b, want 11111", vld_l, nz_l, rdy_l, vld_m, nz_m);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if ({vld_l, out_l} !== {1'b0, 8'h4D}) begin
      bad++; $display("FAIL basic_consume: got v=%b out=%h, want 0 4d", vld_l, out_l);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_word(8'hFF);
    total++;
    if ({vld_l, out_l, out_m} !== {1'b1, 8'hFF, 8'hFF}) begin
      bad++; $display("FAIL bp_first_word: got v=%b out=%h/%h, want 1 ff/ff", vld_l, out_l, out_m);
    end
    send_word(8'h01);
    total++;
    if ({rdy_l, rdy_m, vld_l, out_l} !== {3'b001, 8'hFF}) begin
      bad++; $display("FAIL bp_full: got rdy=%b%b v=%b out=%h, want 00 1 ff", rdy_l, rdy_m, vld_l, out_l);
    end
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    total++;
    if ({rdy_l, vld_l, out_l} !== {2'b01, 8'hFF}) begin
      bad++; $display("FAIL bp_stall: got rdy=%b v=%b out=%h, want 0 1 ff", rdy_l, vld_l, out_l);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++;
    if ({vld_l, out_l, out_m} !== {1'b1, 8'h01, 8'h80}) begin
      bad++; $display("FAIL bp_swap: got v=%b out=%h/%h, want 1 01/80", vld_l, out_l, out_m);
    end
    total++;
    if ({rdy_l, rdy_m} !== 2'b11) begin
      bad++; $display("FAIL bp_ready_back: got rdy=%b%b, want 11", rdy_l, rdy_m);
    end
    tick();
    total++;
    if ({vld_l, vld_m} !== 2'b00) begin
      bad++; $display("FAIL bp_drain: got v=%b%b, want 00", vld_l, vld_m);
    end
  endtask

  task automatic test_mid_reset;
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({out_l, vld_l, nz_l, rdy_l} !== 11'h000) begin
      bad++; $display("FAIL midrst_async: got out=%h v=%b nz=%b rdy=%b, want 00 0 0 0", out_l, vld_l, nz_l, rdy_l);
    end
    @(posedge clk); #2;
    total++;
    if ({rdy_l, rdy_m, vld_l} !== 3'b000) begin
      bad++; $display("FAIL midrst_hold: got rdy=%b%b v=%b, want 000", rdy_l, rdy_m, vld_l);
    end
    rst_n = 1'b1;
    #1;
    send_word(8'hA5);
    total++;
    if ({vld_l, out_l, out_m} !== {1'b1, 8'hA5, rev8(8'hA5)}) begin
      bad++; $display("FAIL midrst_word: got v=%b out=%h/%h, want 1 a5/%h", vld_l, out_l, out_m, rev8(8'hA5));
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_gapped;
    logic [7:0] w;
    w = 8'h3C;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = ~i[0];
      in_bit   = i[0] ? ~w[i/2] : w[i/2];
      tick();
      if (i == 13) begin
        total++;
        if (vld_l !== 1'b0) begin
          bad++; $display("FAIL gap_early: got out_valid=%b after 7 accepted bits, want 0", vld_l);
        end
      end
      if (i == 14) begin
        total++;
        if ({vld_l, out_l, out_m} !== {1'b1, 8'h3C, rev8(8'h3C)}) begin
          bad++; $display("FAIL gap_word: got v=%b out=%h/%h, want 1 3c/%h", vld_l, out_l, out_m, rev8(8'h3C));
        end
      end
    end
    total++;
    if ({vld_l, out_l} !== {1'b0, 8'h3C}) begin
      bad++; $display("FAIL gap_after: got v=%b out=%h, want 0 3c", vld_l, out_l);
    end
  endtask

  task automatic test_zero;
    out_ready = 1'b1;
    send_word(8'h00);
    total++;
    if ({vld_l, out_l, nz_l, vld_m, out_m, nz_m} !== {1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      bad++; $display("FAIL zero_word: got v=%b out=%h nz=%b / v=%b out=%h nz=%b, want 1 00 0", vld_l, out_l, nz_l, vld_m, out_m, nz_m);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_mid_reset();
    test_gapped();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
